// File: rtl/iagc_window_stats_pkg.sv
// ============================================================================
// Module   : iagc_pkg
// Brief    : Status codes and default widths shared by the IAGC sample trigger
//            and the window statistics stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package iagc_pkg;

    localparam int ADC_DATA_SIZE_DEFAULT    = 14;
    localparam int IAGC_STATUS_SIZE_DEFAULT = 4;

    localparam logic [3:0] IAGC_STATUS_RESET = 4'b0000;
    localparam logic [3:0] IAGC_STATUS_INIT  = 4'b0001;

endpackage : iagc_pkg

`default_nettype wire

// File: rtl/iagc_window_stats_if.sv
// ============================================================================
// Module   : iagc_window_stats_if
// Brief    : Sample-in / result-out bundle of the window statistics stage.
//            The slave modport is the statistics block, master is its peer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface iagc_window_stats_if
    import iagc_pkg::*;
#(
    parameter int ADC_DATA_SIZE    = ADC_DATA_SIZE_DEFAULT,
    parameter int IAGC_STATUS_SIZE = IAGC_STATUS_SIZE_DEFAULT
);

    logic [IAGC_STATUS_SIZE-1:0] i_iagc_status;
    logic                        i_sample_valid;
    logic [ADC_DATA_SIZE-1:0]    i_adc_data;
    logic [ADC_DATA_SIZE-1:0]    o_peak;
    logic [ADC_DATA_SIZE-1:0]    o_mean;
    logic                        o_result_valid;
    logic                        i_result_ready;
    logic                        o_overrun;

    modport slave (
        input  i_iagc_status,
        input  i_sample_valid,
        input  i_adc_data,
        input  i_result_ready,
        output o_peak,
        output o_mean,
        output o_result_valid,
        output o_overrun
    );

    modport master (
        output i_iagc_status,
        output i_sample_valid,
        output i_adc_data,
        output i_result_ready,
        input  o_peak,
        input  o_mean,
        input  o_result_valid,
        input  o_overrun
    );

endinterface : iagc_window_stats_if

`default_nettype wire

// File: rtl/iagc_window_stats_sample_magnitude.sv
// ============================================================================
// Module   : sample_magnitude
// Brief    : Combinational saturating absolute value of a signed sample; the
//            most negative code maps to the largest positive code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sample_magnitude #(
    parameter int ADC_DATA_SIZE = 14
) (
    input  logic [ADC_DATA_SIZE-1:0] i_data,
    output logic [ADC_DATA_SIZE-1:0] o_mag
);

    localparam logic [ADC_DATA_SIZE-1:0] c_min_code = {1'b1, {(ADC_DATA_SIZE-1){1'b0}}};
    localparam logic [ADC_DATA_SIZE-1:0] c_max_code = ~c_min_code;

    always_comb begin
        o_mag = i_data;
        if (i_data == c_min_code) begin
            o_mag = c_max_code;
        end else if (i_data[ADC_DATA_SIZE-1]) begin
            o_mag = -i_data;
        end
    end

endmodule : sample_magnitude

`default_nettype wire

// File: rtl/iagc_window_stats.sv
// ============================================================================
// Module   : iagc_window_stats
// Brief    : Per-window peak and mean magnitude of decimated ADC samples,
//            handed to the IAGC controller over valid/ready.
//            Define IAGC_STATS_PEAK_EN to build the peak tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iagc_window_stats
    import iagc_pkg::*;
#(
    parameter int ADC_DATA_SIZE    = ADC_DATA_SIZE_DEFAULT,
    parameter int WINDOW_LOG2      = 4,
    parameter int IAGC_STATUS_SIZE = IAGC_STATUS_SIZE_DEFAULT
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    iagc_window_stats_if.slave  bus
);

    localparam int ACC_W = ADC_DATA_SIZE - 1 + WINDOW_LOG2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [ADC_DATA_SIZE-1:0]   w_mag;
    logic                       w_status_idle;
    logic                       w_step;
    logic                       w_complete;
    logic                       w_load;
    logic [ACC_W-1:0]           w_acc_sum;

    logic [0:0]                 state_q, state_d;
    logic [ADC_DATA_SIZE-1:0]   mag_q, mag_d;
    logic                       mag_vld_q, mag_vld_d;
    logic [WINDOW_LOG2-1:0]     count_q, count_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [ADC_DATA_SIZE-2:0]   mean_q, mean_d;
    logic                       result_valid_q, result_valid_d;
    logic                       overrun_q, overrun_d;

    sample_magnitude #(
        .ADC_DATA_SIZE (ADC_DATA_SIZE)
    ) u_sample_magnitude (
        .i_data (bus.i_adc_data),
        .o_mag  (w_mag)
    );

    always_comb begin
        w_status_idle = (bus.i_iagc_status == IAGC_STATUS_SIZE'(IAGC_STATUS_RESET)) ||
                        (bus.i_iagc_status == IAGC_STATUS_SIZE'(IAGC_STATUS_INIT));
        w_step        = (state_q == ST_ACCUM) && mag_vld_q && !w_status_idle;
        w_complete    = w_step && (count_q == '1);
        // A pending result is only replaced when it is accepted on the same edge.
        w_load        = w_complete && (!result_valid_q || bus.i_result_ready);
        w_acc_sum     = acc_q + ACC_W'(mag_q);

        state_d        = w_status_idle ? ST_IDLE : ST_ACCUM;
        mag_d          = bus.i_sample_valid ? w_mag : mag_q;
        mag_vld_d      = bus.i_sample_valid && !w_status_idle;
        count_d        = count_q;
        acc_d          = acc_q;
        mean_d         = mean_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;

        if (result_valid_q && bus.i_result_ready) begin
            result_valid_d = 1'b0;
        end

        if (w_step) begin
            count_d = count_q + WINDOW_LOG2'(1);
            acc_d   = w_complete ? '0 : w_acc_sum;
        end

        if (w_load) begin
            mean_d         = w_acc_sum[ACC_W-1:WINDOW_LOG2];
            result_valid_d = 1'b1;
        end else if (w_complete) begin
            overrun_d = 1'b1;
        end

        if (w_status_idle) begin
            count_d        = '0;
            acc_d          = '0;
            result_valid_d = 1'b0;
            overrun_d      = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q        <= ST_IDLE;
            mag_q          <= '0;
            mag_vld_q      <= 1'b0;
            count_q        <= '0;
            acc_q          <= '0;
            mean_q         <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mag_q          <= mag_d;
            mag_vld_q      <= mag_vld_d;
            count_q        <= count_d;
            acc_q          <= acc_d;
            mean_q         <= mean_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

`ifdef IAGC_STATS_PEAK_EN
    logic [ADC_DATA_SIZE-1:0] w_peak_max;
    logic [ADC_DATA_SIZE-1:0] peak_run_q, peak_run_d;
    logic [ADC_DATA_SIZE-1:0] peak_q, peak_d;

    always_comb begin
        w_peak_max = (mag_q > peak_run_q) ? mag_q : peak_run_q;
        peak_run_d = peak_run_q;
        peak_d     = peak_q;
        if (w_step) begin
            peak_run_d = w_complete ? '0 : w_peak_max;
        end
        if (w_load) begin
            peak_d = w_peak_max;
        end
        if (w_status_idle) begin
            peak_run_d = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            peak_run_q <= '0;
            peak_q     <= '0;
        end else begin
            peak_run_q <= peak_run_d;
            peak_q     <= peak_d;
        end
    end

    assign bus.o_peak = peak_q;
`else
    assign bus.o_peak = '0;
`endif

    assign bus.o_mean         = {1'b0, mean_q};
    assign bus.o_result_valid = result_valid_q;
    assign bus.o_overrun      = overrun_q;

endmodule : iagc_window_stats

`default_nettype wire

// File: doc/iagc_window_stats.md
# iagc_window_stats

Consumer stage that sits directly downstream of the decimating sample trigger in the IAGC path. On every decimated sample strobe it captures the signed ADC sample, converts it to a saturated magnitude, and accumulates it over a fixed power-of-two window. At the end of each window it presents the window's peak and mean magnitude to the IAGC gain controller through a valid/ready handshake.

## Interface
- `ADC_DATA_SIZE`, 14: width of the signed two's-complement ADC sample.
- `WINDOW_LOG2`, 4: log2 of the samples per window (16 by default); legal range 1..8.
- `IAGC_STATUS_SIZE`, 4: width of the IAGC status word.
- `i_clock` input 1: single clock; all logic is on the rising edge.
- `i_reset_n` input 1: reset, synchronous, active-low.
- `i_iagc_status` input IAGC_STATUS_SIZE: IAGC controller status.
- `i_sample_valid` input 1: decimated sample strobe from the sample trigger.
- `i_adc_data` input ADC_DATA_SIZE: signed ADC sample; qualified by `i_sample_valid`.
- `o_peak` output ADC_DATA_SIZE: maximum magnitude in the window (unsigned, MSB always 0).
- `o_mean` output ADC_DATA_SIZE: window magnitude sum >> WINDOW_LOG2 (truncating).
- `o_result_valid` output 1: result pending.
- `i_result_ready` input 1: controller accepts the result.
- `o_overrun` output 1: sticky; a completed window was discarded.

## Operation
- Magnitude: |x|, with -2^(ADC_DATA_SIZE-1) saturated to 2^(ADC_DATA_SIZE-1)-1.
- Accumulator width is ADC_DATA_SIZE-1+WINDOW_LOG2 bits and never overflows.
- Sample counter width is WINDOW_LOG2 bits and wraps from 2^WINDOW_LOG2-1 to 0.
- States:
  - IDLE: entered on reset, or while the status is RESET (4'b0000) or INIT (4'b0001). Clears the counter, accumulator, running peak, magnitude pipeline, `o_result_valid` and `o_overrun`.
  - ACCUM: entered from IDLE on the first cycle with any other status. Each qualified sample adds its magnitude to the accumulator and updates the running peak.
- Window completion happens when the magnitude of the 2^WINDOW_LOG2-th sample is accumulated:
  - If `o_result_valid`=0, or `i_result_ready`=1 in the same cycle: load `o_peak` and `o_mean` with values that include the final sample, and set `o_result_valid`=1.
  - Otherwise: keep the pending result, discard the new one, and set `o_overrun`=1.
  - In both cases, clear the accumulator and running peak and continue in ACCUM; no sample is lost across the window boundary.
- Handshake: the result is transferred on a cycle with `o_result_valid`=1 and `i_result_ready`=1. After a transfer, `o_result_valid` falls unless a completion loads a new result in the same cycle. `o_peak` and `o_mean` are stable while `o_result_valid`=1.
- A status change to RESET/INIT mid-window aborts the window, and the partial sums are lost. It also drops any pending result and clears `o_overrun`.
- `i_reset_n`=0 dominates status and all inputs.

## Timing
- Reset values: `o_peak`=0, `o_mean`=0, `o_result_valid`=0, `o_overrun`=0.
- Stage 1 registers the magnitude and a valid flag. Stage 2 updates the accumulator and peak.
- Latency: the last window sample strobed at cycle t gives `o_result_valid`=1 at t+2.
- `i_sample_valid` may be asserted on back-to-back cycles; throughput is one sample per clock.
- A status of RESET/INIT at cycle t also flushes the stage-1 sample captured at t.
- `o_overrun` rises at the same edge where the discarded result would have loaded.

## Configuration
- `IAGC_STATS_PEAK_EN` defined: peak tracking is compiled in as described above.
- Not defined: no running-peak register or comparator is built, and `o_peak` is constant 0. The mean path, handshake and overrun behaviour are identical.

## Structure
- Shared package `iagc_pkg` holds `IAGC_STATUS_RESET`=4'b0000, `IAGC_STATUS_INIT`=4'b0001 and the default ADC width. The sample trigger and this block both import these from the package.
- One sub-module, `sample_magnitude`: combinational saturating absolute value, ADC_DATA_SIZE in and out. It is instantiated before the stage-1 register.

## Test plan
- Mean: status=4'b0010, 16 consecutive samples of +100 with ready=1 → `o_mean`=100, `o_peak`=100, and `o_result_valid` pulses once, 2 cycles after the 16th strobe.
- Sign and saturation: samples -8192, -5 and 14×0 → `o_peak`=8191, `o_mean`=(8191+5)>>4=512.
- Overrun: ready=0 through two full windows → the first result is held unchanged and `o_overrun`=1 at the second completion. Then ready=1 for one cycle → the first result transfers and `o_result_valid` falls.
- Back-to-back: ready asserted on the completion cycle of window 2 → the window-2 result loads, `o_result_valid` stays 1 and `o_overrun` stays 0.
- Abort: status→INIT after 7 samples, then a non-reset status, then 16 samples of +40 → `o_mean`=40 with no contamination from the partial window. The same abort applied with `i_reset_n`=0 gives all outputs 0.
- Config: build without `IAGC_STATS_PEAK_EN` and rerun the mean test → `o_peak`=0, `o_mean`=100.
